muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit owning the architectural HI/LO registers. It replaces the single-cycle combinational unsigned divide and the op-gated HI/LO write with a start/busy/done handshake. Supports signed and unsigned multiply and divide, direct HI/LO writes, and pipeline flush. Sits beside the ALU in EX; the hazard unit stalls on busy.

Parameters:
WIDTH, 32, operand and HI/LO width (≥4, even)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request; sampled only when busy=0
op  in  3  operation code (package constants)
a  in  WIDTH  multiplicand / dividend / MTHI-MTLO data
b  in  WIDTH  multiplier / divisor
flush  in  1  abort in-flight operation
busy  out  1  operation in progress
done  out  1  one-cycle pulse: HI/LO just updated
hi  out  WIDTH  HI register (product high / remainder)
lo  out  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset (rst=0, async): hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. Reset mid-operation discards it.
- States: IDLE, CALC, FIX.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU at edge E0:
  - latch |a|, |b| (signed ops) or a, b (unsigned ops) and result sign
  - go to CALC, busy=1 from the next cycle
- CALC: one radix-2 step per edge for WIDTH edges (E1..EWIDTH).
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring step (shift remainder, trial-subtract, set quotient bit).
  - Leave for FIX at EWIDTH.
- FIX (edge EWIDTH+1):
  - apply two's-complement sign correction
  - write hi/lo
  - done=1 for exactly one cycle, busy=0, back to IDLE
  - Latency start→HI/LO valid: WIDTH+1 edges (33 for WIDTH=32). This is constant for all operands.
- Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (either signedness): lo=all ones, hi=a; same latency.
- Signed overflow (a=MIN, b=−1): lo=MIN, hi=0.
- Signed multiply: full 2·WIDTH product, hi=upper WIDTH bits.
- MTHI / MTLO in IDLE: hi (or lo) = a at E0; done=1 the next cycle; busy stays 0.
- Reserved op codes: ignored; no busy, no done, HI/LO unchanged.
- start while busy=1: ignored; the operation is not queued.
- start in the same cycle done=1: accepted, because busy=0.
- flush=1 at an edge:
  - state→IDLE, busy=0, done=0, HI/LO unchanged
  - flush beats start in the same cycle, including MTHI/MTLO
- Operands are captured at E0; changes on a/b/op during CALC have no effect.
- hi/lo change only at FIX or on an MTHI/MTLO edge.

Decomposition:
- Shared package muldiv_pkg:
  - op constants MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5
  - state encoding IDLE/CALC/FIX
- One sub-module muldiv_step: purely combinational single iteration. Inputs: mode (mul/div), accumulator, operand. Outputs: next accumulator. The top holds the registers, counter, FSM and sign fix-up.

Test Plan (WIDTH=32):
- MULT a=FFFFFFFF, b=00000002 → after 33 edges hi=FFFFFFFF, lo=FFFFFFFE, done pulse 1 cycle; MULTU same operands → hi=00000001, lo=FFFFFFFE.
- DIV a=FFFFFFF9 (−7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=100, b=7 → lo=0000000E, hi=00000002.
- Boundaries:
  - DIVU a=5, b=0 → lo=FFFFFFFF, hi=00000005
  - DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=00000000
  - both take 33 edges
- Handshake:
  - start DIVU while busy → ignored, first result unchanged
  - start asserted in done cycle → accepted, busy high next cycle
- Abort paths:
  - flush at edge 10 of a MULT → busy=0, no done, hi/lo keep prior values
  - rst low mid-CALC → hi=lo=0, busy=0 immediately (asynchronous)
- MTHI a=12345678 then MTLO a=9ABCDEF0 on consecutive cycles → hi=12345678, lo=9ABCDEF0, two done pulses, busy never high.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and op-classification helpers for the
// iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: LSB-first shift-add multiply or restoring divide
// on a {high, low} double-width accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 mode_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] diff_s;

  // Multiply consumes the multiplier from acc[0]; divide shifts the dividend
  // out of the low half into the remainder and shifts quotient bits in.
  always_comb begin
    sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
    // The true difference is below the divisor, so WIDTH bits suffice.
    diff_s   = rem_sh_s[WIDTH-1:0] - opnd;
    if (mode_div) begin
      if (rem_sh_s >= {1'b0, opnd}) begin
        acc_next = {diff_s, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else if (acc[0]) begin
      acc_next = {sum_s, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit owning HI/LO, with a
// start/busy/done handshake, MTHI/MTLO writes and flush.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int DW    = 2 * WIDTH;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] x);
    return ~x + DW'(1);
  endfunction

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [DW-1:0]    step_next_s;
  logic             a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [DW-1:0]    prod_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (is_div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (step_next_s)
  );

  // Next-state logic; flush overrides everything including an IDLE start.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    a_neg_s   = is_signed_op(op) & a[WIDTH-1];
    b_neg_s   = is_signed_op(op) & b[WIDTH-1];
    a_mag_s   = a_neg_s ? neg_w(a) : a;
    b_mag_s   = b_neg_s ? neg_w(b) : b;
    prod_s    = neg_res_q ? neg_dw(acc_q) : acc_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                is_div_d  = is_div_op(op);
                neg_res_d = a_neg_s ^ b_neg_s;
                neg_rem_d = a_neg_s;
                dz_d      = (b == '0);
                acc_d     = is_div_op(op) ? {{WIDTH{1'b0}}, a_mag_s}
                                          : {{WIDTH{1'b0}}, b_mag_s};
                opnd_d    = is_div_op(op) ? b_mag_s : a_mag_s;
                cnt_d     = '0;
                busy_d    = 1'b1;
                state_d   = CALC;
              end
              MD_MTHI: begin
                hi_d   = a;
                done_d = 1'b1;
              end
              MD_MTLO: begin
                lo_d   = a;
                done_d = 1'b1;
              end
              default: begin
                state_d = IDLE;
              end
            endcase
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          acc_d = step_next_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
        FIX: begin
          // Divide by zero keeps lo all ones; hi recovers a via the remainder sign.
          if (is_div_q) begin
            lo_d = dz_q ? '1 : (neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]);
            hi_d = neg_rem_q ? neg_w(acc_q[DW-1:WIDTH]) : acc_q[DW-1:WIDTH];
          end else begin
            lo_d = prod_s[WIDTH-1:0];
            hi_d = prod_s[DW-1:WIDTH];
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32) with hand-computed
// results, latency, handshake, flush and reset checks.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk, rst, start, flush, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  int          n_vec = 0;
  int          n_err = 0;
  int          lat, nd, busy_seen;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Bounded wait for done; returns edges waited, or 99 if it never came.
  task automatic wait_done(output int n);
    n = 99;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  // Issue one op at edge E0, scramble operands afterwards, wait for done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int n);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h0000_0001; op = MD_MULT;
    check("busy_after_E0", {63'd0, busy}, 64'd1);
    wait_done(n);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    #12;
    check("reset_state", {30'd0, busy, done, hi ^ lo, lo}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002, lat);
    check("mult_lat", 64'(lat), 64'd33);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    check("mult_busy_at_done", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    check("mult_done_pulse", {63'd0, done}, 64'd0);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, lat);
    check("multu_lat", 64'(lat), 64'd33);
    check("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat);
    check("div_neg_lat", 64'(lat), 64'd33);
    check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(MD_DIVU, 32'd100, 32'd7, lat);
    check("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    run_op(MD_DIVU, 32'd5, 32'd0, lat);
    check("divu_zero_lat", 64'(lat), 64'd33);
    check("divu_zero_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_ovf_lat", 64'(lat), 64'd33);
    check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, lat);
    check("div_zero_signed", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);

    run_op(MD_DIV, 32'd17, 32'hFFFF_FFFB, lat);
    check("div_pos_by_neg", {hi, lo}, 64'h0000_0002_FFFF_FFFD);

    run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, lat);
    check("mult_min_min", {hi, lo}, 64'h4000_0000_0000_0000);

    run_op(MD_MULT, 32'h0001_2345, 32'hFFFF_FFFD, lat);
    check("mult_pos_neg", {hi, lo}, 64'hFFFF_FFFF_FFFC_9631);

    // start while busy is ignored and not queued
    op = MD_MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(lat);
    check("busy_start_lat", 64'(lat), 64'd28);
    check("busy_start_hilo", {hi, lo}, 64'h0000_0000_0000_000F);
    count_done(40, nd);
    check("busy_start_not_queued", {32'(nd), 31'd0, busy}, 64'd0);

    // start in the done cycle is accepted
    op = MD_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(lat);
    check("b2b_first_lat", 64'(lat), 64'd33);
    check("b2b_first_lo", {hi, lo}, 64'h0000_0000_0000_002A);
    op = MD_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("b2b_busy_next", {62'd0, busy, done}, 64'd2);
    wait_done(lat);
    check("b2b_second_lat", 64'(lat), 64'd33);
    check("b2b_second_lo", {hi, lo}, 64'h0000_0000_0000_0006);

    // flush at edge 10 of a MULT
    op = MD_MULT; a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy_done", {62'd0, busy, done}, 64'd0);
    count_done(40, nd);
    check("flush_no_done", 64'(nd), 64'd0);
    check("flush_hilo_kept", {hi, lo}, 64'h0000_0000_0000_0006);

    // flush beats an MTHI start
    op = MD_MTHI; a = 32'h0000_DEAD; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    check("flush_mthi_done", {62'd0, busy, done}, 64'd0);
    check("flush_mthi_hi", {hi, lo}, 64'h0000_0000_0000_0006);

    // reserved op is ignored
    op = 3'd6; a = 32'h1111_1111; b = 32'h2222_2222; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("rsvd_busy_done", {62'd0, busy, done}, 64'd0);
    count_done(5, nd);
    check("rsvd_no_done", {32'(nd), 31'd0, busy}, 64'd0);
    check("rsvd_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

    // MTHI then MTLO on consecutive cycles
    busy_seen = 0;
    op = MD_MTHI; a = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    if (busy) busy_seen++;
    check("mthi_done", {62'd0, busy, done}, 64'd1);
    check("mthi_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    op = MD_MTLO; a = 32'h9ABC_DEF0;
    @(posedge clk); #1; start = 1'b0;
    if (busy) busy_seen++;
    check("mtlo_done", {62'd0, busy, done}, 64'd1);
    @(posedge clk); #1;
    if (busy) busy_seen++;
    check("mt_pulse_end", {62'd0, busy, done}, 64'd0);
    check("mt_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    check("mt_busy_never", 64'(busy_seen), 64'd0);

    // asynchronous reset mid-CALC
    op = MD_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst = 1'b0;
    #1;
    check("async_rst_hilo", {hi, lo}, 64'd0);
    check("async_rst_busy", {62'd0, busy, done}, 64'd0);
    #2; rst = 1'b1;
    @(posedge clk); #1;
    run_op(MD_DIVU, 32'd100, 32'd7, lat);
    check("post_rst_lat", 64'(lat), 64'd33);
    check("post_rst_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
